// File: rtl/sha256_w_mem_loader_pkg.sv
// rtl/sha256_w_mem_loader_pkg.sv - shared widths and loader state encoding
package sha256_w_mem_loader_pkg;

  localparam int SHA256_WORD_WIDTH  = 32;
  localparam int SHA256_BLOCK_WORDS = 16;
  localparam int SHA256_BLOCK_BYTES = 64;

  // 2'd3 is unused and decodes back to ST_IDLE
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_FULL = 2'd2
  } loader_state_e;

endpackage

// File: rtl/sha256_w_mem_loader_packer.sv
// rtl/sha256_w_mem_loader_packer.sv - big-endian byte-to-word shift packer
module sha256_byte_packer
  import sha256_w_mem_loader_pkg::*;
(
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         clear,
  input  logic                         in_accept,
  input  logic [7:0]                   in_byte,
  output logic                         word_valid,
  output logic [SHA256_WORD_WIDTH-1:0] word
);

  logic [23:0]                  pack_q, pack_d;
  logic [1:0]                   lane_q, lane_d;
  logic                         word_valid_q, word_valid_d;
  logic [SHA256_WORD_WIDTH-1:0] word_q, word_d;

  always_comb begin
    pack_d       = pack_q;
    lane_d       = lane_q;
    word_valid_d = 1'b0;
    word_d       = word_q;
    if (clear) begin
      pack_d = '0;
      lane_d = '0;
    end else if (in_accept) begin
      pack_d = {pack_q[15:0], in_byte};
      lane_d = lane_q + 2'd1;
      // fourth byte of the group completes the word; it is presented next cycle
      if (lane_q == 2'd3) begin
        word_valid_d = 1'b1;
        word_d       = {pack_q, in_byte};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      pack_q       <= '0;
      lane_q       <= '0;
      word_valid_q <= 1'b0;
      word_q       <= '0;
    end else begin
      pack_q       <= pack_d;
      lane_q       <= lane_d;
      word_valid_q <= word_valid_d;
      word_q       <= word_d;
    end
  end

  assign word_valid = word_valid_q;
  assign word       = word_q;

endmodule

// File: rtl/sha256_w_mem_loader.sv
// rtl/sha256_w_mem_loader.sv - packs a byte stream into the SHA-256 W RAM, one block at a time
module sha256_w_mem_loader
  import sha256_w_mem_loader_pkg::*;
#(
  parameter int WORD_COUNT = 16,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         start,
  input  logic [7:0]                   in_data,
  input  logic                         in_valid,
  output logic                         in_ready,
  output logic                         wr_en,
  output logic [ADDR_WIDTH-1:0]        wr_addr,
  output logic [SHA256_WORD_WIDTH-1:0] wr_data,
  output logic                         block_valid,
  input  logic                         block_ack,
  output logic                         busy
);

  localparam int CNT_W = ADDR_WIDTH + 2;
  localparam logic [CNT_W-1:0] LAST_BYTE = CNT_W'(WORD_COUNT * 4 - 1);

  loader_state_e         state_q, state_d;
  logic [CNT_W-1:0]      byte_cnt_q, byte_cnt_d;
  logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
  logic                  block_valid_q, block_valid_d;
  logic                  busy_q, busy_d;
  logic                  accept;
  logic                  pack_clear;

  assign in_ready   = (state_q == ST_LOAD);
  assign accept     = in_ready && in_valid;
  assign pack_clear = (state_q == ST_IDLE) && start;

  always_comb begin
    state_d    = state_q;
    byte_cnt_d = byte_cnt_q;
    wr_addr_d  = wr_addr_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d    = ST_LOAD;
          byte_cnt_d = '0;
        end
      end
      ST_LOAD: begin
        if (accept) begin
          byte_cnt_d = byte_cnt_q + 1'b1;
          if (byte_cnt_q[1:0] == 2'd3) wr_addr_d = byte_cnt_q[CNT_W-1:2];
          if (byte_cnt_q == LAST_BYTE) state_d = ST_FULL;
        end
      end
      ST_FULL: begin
        if (block_ack) state_d = ST_IDLE;
      end
      default: begin
        state_d    = ST_IDLE;
        byte_cnt_d = '0;
      end
    endcase
    // outputs track the next state so they line up with state_q
    block_valid_d = (state_d == ST_FULL);
    busy_d        = (state_d == ST_LOAD) || (state_d == ST_FULL);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q       <= ST_IDLE;
      byte_cnt_q    <= '0;
      wr_addr_q     <= '0;
      block_valid_q <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      byte_cnt_q    <= byte_cnt_d;
      wr_addr_q     <= wr_addr_d;
      block_valid_q <= block_valid_d;
      busy_q        <= busy_d;
    end
  end

  sha256_byte_packer u_packer (
    .clk        (clk),
    .reset_n    (reset_n),
    .clear      (pack_clear),
    .in_accept  (accept),
    .in_byte    (in_data),
    .word_valid (wr_en),
    .word       (wr_data)
  );

  assign wr_addr     = wr_addr_q;
  assign block_valid = block_valid_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_sha256_w_mem_loader.sv
// tb/tb_sha256_w_mem_loader.sv - directed self-checking bench for sha256_w_mem_loader
module tb_sha256_w_mem_loader;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_ready;
  logic        wr_en;
  logic [3:0]  wr_addr;
  logic [31:0] wr_data;
  logic        block_valid;
  logic        block_ack;
  logic        busy;

  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          wr_cnt = 0;
  int          wr_cyc [0:255];
  logic [31:0] mem [0:15];

  sha256_w_mem_loader #(.WORD_COUNT(16), .ADDR_WIDTH(4)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .start       (start),
    .in_data     (in_data),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .wr_en       (wr_en),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .block_valid (block_valid),
    .block_ack   (block_ack),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // RAM model fed from the write port, sampled mid-cycle
  always @(negedge clk) begin
    if (wr_en === 1'b1) begin
      mem[wr_addr]   <= wr_data;
      wr_cyc[wr_cnt] <= cyc;
      wr_cnt         <= wr_cnt + 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    in_data  = b;
    in_valid = 1'b1;
    step();
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_in_ready"}, {31'd0, in_ready}, 32'd0);
    chk({tag, "_wr_en"}, {31'd0, wr_en}, 32'd0);
    chk({tag, "_wr_addr"}, {28'd0, wr_addr}, 32'd0);
    chk({tag, "_wr_data"}, wr_data, 32'd0);
    chk({tag, "_block_valid"}, {31'd0, block_valid}, 32'd0);
    chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
  endtask

  function automatic logic [7:0] abc_byte(input int i);
    case (i)
      0:       return 8'h61;
      1:       return 8'h62;
      2:       return 8'h63;
      3:       return 8'h80;
      63:      return 8'h18;
      default: return 8'h00;
    endcase
  endfunction

  initial begin
    int base;
    int first_cyc;
    reset_n   = 1'b0;
    start     = 1'b0;
    in_data   = 8'h00;
    in_valid  = 1'b0;
    block_ack = 1'b0;
    step();
    step();
    chk_reset_vals("reset");
    reset_n = 1'b1;
    step();
    chk("idle_in_ready", {31'd0, in_ready}, 32'd0);

    // "abc" block, back-to-back bytes
    base  = wr_cnt;
    start = 1'b1;
    step();
    start = 1'b0;
    chk("load_in_ready", {31'd0, in_ready}, 32'd1);
    chk("load_busy", {31'd0, busy}, 32'd1);
    first_cyc = cyc;
    for (int i = 0; i < 63; i++) send_byte(abc_byte(i));
    chk("abc_bv_before_last", {31'd0, block_valid}, 32'd0);
    send_byte(abc_byte(63));
    in_valid = 1'b0;
    chk("abc_last_wr_en", {31'd0, wr_en}, 32'd1);
    chk("abc_last_addr", {28'd0, wr_addr}, 32'd15);
    chk("abc_last_data", wr_data, 32'h0000_0018);
    chk("abc_bv_with_last", {31'd0, block_valid}, 32'd1);
    step();
    chk("abc_wr_count", wr_cnt - base, 16);
    chk("abc_w0", mem[0], 32'h6162_6380);
    chk("abc_w7", mem[7], 32'h0000_0000);
    chk("abc_w14", mem[14], 32'h0000_0000);
    chk("abc_w15", mem[15], 32'h0000_0018);
    chk("thr_first_write", wr_cyc[base] - first_cyc, 4);
    for (int k = 0; k < 15; k++)
      chk($sformatf("thr_gap_%0d", k), wr_cyc[base+k+1] - wr_cyc[base+k], 4);
    block_ack = 1'b1;
    step();
    block_ack = 1'b0;
    chk("abc_ack_bv", {31'd0, block_valid}, 32'd0);
    chk("abc_ack_busy", {31'd0, busy}, 32'd0);

    // bubbles: one byte every other cycle
    base  = wr_cnt;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 64; i++) begin
      send_byte(8'(i));
      in_valid = 1'b0;
      step();
    end
    chk("bub_wr_count", wr_cnt - base, 16);
    chk("bub_w0", mem[0], 32'h0001_0203);
    chk("bub_w2", mem[2], 32'h0809_0A0B);
    chk("bub_w15", mem[15], 32'h3C3D_3E3F);
    chk("bub_bv", {31'd0, block_valid}, 32'd1);

    // FULL ignores in_valid and start
    in_valid = 1'b1;
    start    = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      chk($sformatf("full_in_ready_%0d", i), {31'd0, in_ready}, 32'd0);
      chk($sformatf("full_wr_en_%0d", i), {31'd0, wr_en}, 32'd0);
    end
    chk("full_no_writes", wr_cnt - base, 16);
    block_ack = 1'b1;
    step();
    block_ack = 1'b0;
    start     = 1'b0;
    in_valid  = 1'b0;
    chk("full_ack_bv", {31'd0, block_valid}, 32'd0);
    chk("full_ack_busy", {31'd0, busy}, 32'd0);
    step();
    chk("full_ack_start_ignored", {31'd0, busy}, 32'd0);

    // reset in the middle of a load
    start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 22; i++) send_byte(8'hA0 + 8'(i));
    in_valid = 1'b0;
    base     = wr_cnt;
    reset_n  = 1'b0;
    step();
    chk_reset_vals("midreset");
    reset_n = 1'b1;
    step();
    chk("midreset_after_wr_en", {31'd0, wr_en}, 32'd0);
    chk("midreset_no_writes", wr_cnt - base, 0);

    // fresh block with a stray start at byte 10
    base  = wr_cnt;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 64; i++) begin
      start = (i == 10);
      send_byte(8'h10 + 8'(i));
    end
    start    = 1'b0;
    in_valid = 1'b0;
    chk("restart_bv", {31'd0, block_valid}, 32'd1);
    chk("restart_last_addr", {28'd0, wr_addr}, 32'd15);
    step();
    chk("restart_wr_count", wr_cnt - base, 16);
    chk("restart_w0", mem[0], 32'h1011_1213);
    chk("restart_w3", mem[3], 32'h1C1D_1E1F);
    chk("restart_w15", mem[15], 32'h4C4D_4E4F);
    block_ack = 1'b1;
    step();
    block_ack = 1'b0;
    chk("restart_ack_busy", {31'd0, busy}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
